sram_bank_sched: RTL
====================

# sram_bank_sched

Bank-conflict scheduler between the four SIMT lanes' load/store unit and the 4-bank `sram_fp` scratchpad. Accepts one warp-wide memory request (up to four lane accesses), splits it into conflict-free rounds where no two issued lanes hit the same bank, drives `sram_fp` one round per cycle, and returns gathered read data as one response. The core stalls on `req_ready` while a request is in flight.

## Interface
- `NLANES`, 4: lanes and SRAM ports, fixed at 4.
- `ADDR_W`, 14: word address width.
- `DATA_W`, 32: data width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: warp request present.
- `req_ready` out 1: high only in IDLE; the request is accepted on an edge with `req_valid && req_ready`.
- `req_mask` in 4: active lanes.
- `req_we` in 4: per-lane write, 0 = read.
- `req_addr0..3` in 14 each: per-lane word address.
- `req_wd0..3` in 32 each: per-lane write data.
- `resp_valid` out 1: one-cycle pulse, response complete.
- `resp_rd0..3` out 32 each: read data per lane, held until the next acceptance. Write lanes and inactive lanes return 0.
- `m_en` out 4: SRAM port enable. `sram_fp` ignores ports with `m_en=0`.
- `m_addr0..3`, `m_we0..3`, `m_wd0..3` out: SRAM port i carries lane i.
- `m_rd0..3` in 32 each: SRAM read data, valid the cycle after issue.

## Operation
- **Bank mapping:** `bank = addr[1:0]`.
- **Acceptance:** on acceptance, the block registers all request fields and sets `pend = req_mask`.
- **Round selection:** for each bank, pick the lowest-index pending lane targeting it. The selected set is `issue`.
- **Issue cycle:** drive `m_en = issue`, with addr/we/wd from the registered lane values. Clear `issue` from `pend`.
- **Write ordering:** the lower lane always writes first. For two writes to the same address, the higher lane's value survives.
- **Read capture:** `cap` is the registered copy of `issue`. In the following cycle, for each lane in `cap` with `we=0`, latch `m_rdi` into the lane's result register.
- **FSM states:**
  - IDLE: `req_ready=1`.
  - ISSUE: one round per cycle. Go to DRAIN when `pend` becomes 0 after this round.
  - DRAIN: capture the last round's read data, `m_en=0`.
  - RESP: `resp_valid=1` for one cycle, then IDLE.
- **Empty mask:** `req_mask == 0` goes IDLE → RESP directly.
- **Round count:** R = max lanes sharing one bank, range 1–4.
- **`req_valid` during busy:** ignored. There is no queueing.
- **Reset values (any time, including mid-operation):**
  - State IDLE, `pend=0`, `cap=0`.
  - `m_en=0`, all `m_we=0`, `m_addr`/`m_wd` = 0.
  - `resp_valid=0`, results = 0, `req_ready=1` from the first post-reset cycle.
  - In-flight writes already issued stay in SRAM. Unissued writes are dropped.

## Timing
- **Acceptance to `resp_valid`:** acceptance at edge E. Round k is issued in cycle E+k (k = 1..R). DRAIN is cycle E+R+1. `resp_valid` is high in cycle E+R+2.
- **Empty mask:** `resp_valid` in cycle E+1.
- **Next acceptance:** earliest at the edge ending cycle E+R+3 (IDLE).
- **Throughput:** one warp request per R+3 cycles.
- **Output registers:** `m_*` outputs are registered. `issue` selection is combinational from `pend`.

## Configuration
- **`SRAM_BCAST_EN` defined:**
  - Pending read lanes whose full address equals the selected read lane's address issue in the same round (broadcast).
  - `sram_fp` must tolerate identical-address reads on multiple ports.
  - Writes never merge.
- **`SRAM_BCAST_EN` undefined:** same-address lanes count as bank conflicts and serialize.

## Structure
- **Package `simt_mem_pkg`:**
  - `NLANES`, `ADDR_W`, `DATA_W`, `BANK_W=2`.
  - `bank_of()` function.
  - `sched_state_t` enum (IDLE, ISSUE, DRAIN, RESP).
- **Sub-module `sram_bank_pick`:** combinational. Inputs are `pend`, four addresses and `we`. Output is the `issue` mask, with the broadcast merge under the macro. The FSM and lane registers live in `sram_bank_sched`.

## Test plan
- **No conflict:** mask 1111 reads at addrs 5, 2, 3, 0 (after prefill 456, 5555, 789, 123). Expect R=1, `resp_valid` at E+3, `rd` = 456, 5555, 789, 123.
- **Full conflict:** mask 1111 writes addrs 0, 4, 8, 12 with data 1–4, then reads them back. Expect `m_en` = 0001, 0010, 0100, 1000 in successive cycles, `resp_valid` at E+6, readback 1, 2, 3, 4.
- **Write order:** lanes 0 and 2 write addr 7 with 11 and 22, lanes 1 and 3 masked off. Expect 2 rounds; a subsequent read of addr 7 returns 22.
- **Broadcast:** four reads of addr 5 (holding 456). With `SRAM_BCAST_EN`: one round with `m_en=1111`. Without: four rounds. Both return 456 on all lanes.
- **Reset mid-issue:** reset in cycle E+2 of the full-conflict write. The next cycle shows `req_ready=1`, `m_en=0`, `resp_valid=0`. Readback gives addr 0 = 1 and addr 4 = 2 only (assuming writes for cycles E+1 and E+2 landed per the issued rounds).
- **Empty mask:** `req_mask=0000`. Expect `resp_valid` at E+1 with all `rd=0`, and no `m_en` activity.

Source files
------------

// File: rtl/simt_mem_pkg.sv
// Shared definitions for the SIMT lane / scratchpad memory path.
// Contents:
//   NLANES, ADDR_W, DATA_W, BANK_W  - geometry of the lane group and scratchpad
//   bank_of()                       - word address -> bank index
//   sched_state_t                   - bank scheduler FSM states
package simt_mem_pkg;

  localparam int NLANES = 4;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int BANK_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } sched_state_t;

  // Banks are word-interleaved: consecutive words land in consecutive banks.
  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
    return addr[BANK_W-1:0];
  endfunction

endpackage

// File: rtl/sram_bank_sched_if.sv
// Warp memory request/response bus between the load/store unit and the
// bank scheduler.
// Signals:
//   req_valid/req_ready          - request handshake (accepted when both high)
//   req_mask, req_we             - per-lane active and write flags
//   req_addr0..3, req_wd0..3     - per-lane word address and write data
//   resp_valid                   - one-cycle pulse when the warp response is complete
//   resp_rd0..3                  - per-lane read data
// Modports: master = load/store unit side, slave = scheduler side.
interface sram_bank_sched_if;
  import simt_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [NLANES-1:0] req_mask;
  logic [NLANES-1:0] req_we;
  logic [ADDR_W-1:0] req_addr0, req_addr1, req_addr2, req_addr3;
  logic [DATA_W-1:0] req_wd0, req_wd1, req_wd2, req_wd3;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rd0, resp_rd1, resp_rd2, resp_rd3;

  modport master (
    output req_valid, req_mask, req_we,
    output req_addr0, req_addr1, req_addr2, req_addr3,
    output req_wd0, req_wd1, req_wd2, req_wd3,
    input  req_ready, resp_valid,
    input  resp_rd0, resp_rd1, resp_rd2, resp_rd3
  );

  modport slave (
    input  req_valid, req_mask, req_we,
    input  req_addr0, req_addr1, req_addr2, req_addr3,
    input  req_wd0, req_wd1, req_wd2, req_wd3,
    output req_ready, resp_valid,
    output resp_rd0, resp_rd1, resp_rd2, resp_rd3
  );

endinterface

// File: rtl/sram_bank_pick.sv
// Combinational round selection for the bank scheduler: from the set of
// pending lanes, choose at most one lane per bank (the lowest-index one).
// Optional feature macro: SRAM_BCAST_EN - pending read lanes whose full
// address equals the chosen read lane of their bank join the same round.
// Ports:
//   pend  in  - lanes still waiting to be issued
//   addr  in  - per-lane word address
//   we    in  - per-lane write flag
//   issue out - lanes to issue this round
module sram_bank_pick
  import simt_mem_pkg::*;
(
  input  logic [NLANES-1:0]             pend,
  input  logic [NLANES-1:0][ADDR_W-1:0] addr,
  input  logic [NLANES-1:0]             we,
  output logic [NLANES-1:0]             issue
);

  logic [NLANES-1:0] first;

  // A lane owns its bank this round unless a lower pending lane maps there;
  // this is also what keeps lower-lane writes ahead of higher-lane ones.
  always_comb begin
    first = '0;
    for (int i = 0; i < NLANES; i++) begin
      first[i] = pend[i];
      for (int j = 0; j < i; j++)
        if (pend[j] && bank_of(addr[j]) == bank_of(addr[i])) first[i] = 1'b0;
    end
  end

`ifdef SRAM_BCAST_EN
  // A winning read broadcasts to later reads of the identical word.
  // Writes never merge, so the write-order guarantee is unaffected.
  always_comb begin
    issue = first;
    for (int i = 0; i < NLANES; i++)
      for (int j = 0; j < i; j++)
        if (pend[i] && !we[i] && first[j] && !we[j] && addr[j] == addr[i])
          issue[i] = 1'b1;
  end
`else
  logic unused_we;
  assign unused_we = ^we;
  assign issue     = first;
`endif

endmodule

// File: rtl/sram_bank_sched.sv
// Bank-conflict scheduler between the 4 SIMT lanes and the 4-bank sram_fp
// scratchpad. A warp request is split into conflict-free rounds issued one
// per cycle; read data is gathered and returned as one response.
// Optional feature macro: SRAM_BCAST_EN (same-address read broadcast, see
// sram_bank_pick).
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   bus (slave)         - warp request/response bus
//   m_en                - per-port SRAM enable (port i carries lane i)
//   m_addr0..3, m_we0..3, m_wd0..3 - registered SRAM port controls
//   m_rd0..3            - SRAM read data, valid the cycle after issue
module sram_bank_sched
  import simt_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  sram_bank_sched_if.slave  bus,
  output logic [NLANES-1:0] m_en,
  output logic [ADDR_W-1:0] m_addr0, m_addr1, m_addr2, m_addr3,
  output logic              m_we0, m_we1, m_we2, m_we3,
  output logic [DATA_W-1:0] m_wd0, m_wd1, m_wd2, m_wd3,
  input  logic [DATA_W-1:0] m_rd0, m_rd1, m_rd2, m_rd3
);

  sched_state_t state, next_state;
  logic accept;
  logic [NLANES-1:0] pend, cap, issue, lane_we, pick_pend, pick_we, m_we_q;
  logic [NLANES-1:0][ADDR_W-1:0] req_addr, lane_addr, pick_addr, m_addr_q;
  logic [NLANES-1:0][DATA_W-1:0] req_wd, lane_wd, pick_wd, m_wd_q, m_rd, result;

  assign req_addr = {bus.req_addr3, bus.req_addr2, bus.req_addr1, bus.req_addr0};
  assign req_wd   = {bus.req_wd3, bus.req_wd2, bus.req_wd1, bus.req_wd0};
  assign m_rd     = {m_rd3, m_rd2, m_rd1, m_rd0};

  assign accept         = bus.req_valid && (state == IDLE);
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rd0   = result[0];
  assign bus.resp_rd1   = result[1];
  assign bus.resp_rd2   = result[2];
  assign bus.resp_rd3   = result[3];

  assign {m_addr3, m_addr2, m_addr1, m_addr0} = m_addr_q;
  assign {m_we3, m_we2, m_we1, m_we0}         = m_we_q;
  assign {m_wd3, m_wd2, m_wd1, m_wd0}         = m_wd_q;

  // The SRAM ports are registered, so round 1 has to be picked straight from
  // the incoming request on the accepting edge; later rounds come from the
  // lane registers.
  always_comb begin
    pick_pend = pend;
    pick_we   = lane_we;
    pick_addr = lane_addr;
    pick_wd   = lane_wd;
    if (state == IDLE) begin
      pick_pend = accept ? bus.req_mask : '0;
      pick_we   = bus.req_we;
      pick_addr = req_addr;
      pick_wd   = req_wd;
    end
  end

  sram_bank_pick u_pick (
    .pend  (pick_pend),
    .addr  (pick_addr),
    .we    (pick_we),
    .issue (issue)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // ISSUE lasts while rounds are being loaded; once pend is empty the last
  // round is on the ports, and DRAIN waits for its read data.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (bus.req_mask == '0) ? RESP : ISSUE;
      ISSUE:   if (pend == '0) next_state = DRAIN;
      DRAIN:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Unissued lanes get zeroed port fields so the SRAM bus stays quiet.
  // cap trails m_en by one cycle, lining up with the SRAM read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= '0;
      cap       <= '0;
      m_en      <= '0;
      m_we_q    <= '0;
      m_addr_q  <= '0;
      m_wd_q    <= '0;
      lane_we   <= '0;
      lane_addr <= '0;
      lane_wd   <= '0;
      result    <= '0;
    end else begin
      pend   <= pick_pend & ~issue;
      m_en   <= issue;
      m_we_q <= issue & pick_we;
      cap    <= m_en;
      for (int i = 0; i < NLANES; i++) begin
        m_addr_q[i] <= issue[i] ? pick_addr[i] : '0;
        m_wd_q[i]   <= (issue[i] && pick_we[i]) ? pick_wd[i] : '0;
        if (accept)                     result[i] <= '0;
        else if (cap[i] && !lane_we[i]) result[i] <= m_rd[i];
      end
      if (accept) begin
        lane_we   <= bus.req_we;
        lane_addr <= req_addr;
        lane_wd   <= req_wd;
      end
    end
  end

endmodule
